pc_sequencer: RTL and testbench

- Owns the architectural PC register of the 8-bit core.
- Consumes the sequential-successor address from the PC-increment block and selects the next PC among sequential, relative branch, absolute jump, call and return.
- Keeps a small hardware return-address stack and a RUN/HALT/FAULT state machine.
- Its PC output feeds instruction fetch and the PC-increment block, closing the loop.

---
 rtl/pc_sequencer_if.sv | 37 +++
 rtl/pc_sequencer.sv | 117 +++++++++++
 tb/tb_pc_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Bundle between the PC sequencer and the rest of the core: control inputs,
// the sequential successor address, and the registered PC/stack/state outputs.
interface pc_sequencer_if #(
   parameter int AW    = 8,
   parameter int DEPTH = 4
);
   localparam int DW = $clog2(DEPTH) + 1;

   logic [AW-1:0] Next_PC;
   logic          Stall;
   logic          Branch_Taken;
   logic [AW-1:0] Branch_Offset;
   logic          Jump;
   logic [AW-1:0] Jump_Addr;
   logic          Call;
   logic          Ret;
   logic          Halt;
   logic          Resume;
   logic [AW-1:0] PC;
   logic [DW-1:0] Stack_Depth;
   logic          Halted;
   logic          Fault;

   // Core side: drives controls, observes the PC and status.
   modport master (
      output Next_PC, Stall, Branch_Taken, Branch_Offset, Jump, Jump_Addr,
             Call, Ret, Halt, Resume,
      input  PC, Stack_Depth, Halted, Fault
   );

   // Sequencer side.
   modport slave (
      input  Next_PC, Stall, Branch_Taken, Branch_Offset, Jump, Jump_Addr,
             Call, Ret, Halt, Resume,
      output PC, Stack_Depth, Halted, Fault
   );
endinterface

// File: rtl/pc_sequencer.sv
// Architectural PC register of the 8-bit core. Picks the next PC among
// sequential / relative branch / absolute jump / call / return, keeps a small
// LIFO return-address stack and a RUN/HALT/FAULT state machine.
module pc_sequencer #(
   parameter int            AW       = 8,
   parameter int            DEPTH    = 4,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic            Clk,
   input  logic            Clear_n,
   pc_sequencer_if.slave   bus
);
   localparam int DW = $clog2(DEPTH) + 1;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [DW-1:0] depth_q, depth_d;
   logic [AW-1:0] stack_q [DEPTH];
   logic          push_en;
   logic [IW-1:0] push_idx;
   logic [IW-1:0] top_idx;

   // Relative branch target: offset is two's complement, result wraps mod 2^AW.
   function automatic logic [AW-1:0] branch_target(input logic [AW-1:0]        pc,
                                                   input logic signed [AW-1:0] off);
      logic [AW-1:0] sum;
      sum = pc + $unsigned(off);
      return sum;
   endfunction

   // Entries are addressed by the current depth: push writes slot depth,
   // pop reads slot depth-1. The top read is only used when depth is nonzero.
   assign push_idx = IW'(depth_q);
   assign top_idx  = IW'(depth_q - DW'(1));

   // Next-state selection; one action per cycle in the priority order
   // Halt > Ret > Call > Jump > Branch > sequential.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      depth_d = depth_q;
      push_en = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (!bus.Stall) begin
               if (bus.Halt) begin
                  state_d = ST_HALT;
               end else if (bus.Ret) begin
                  if (depth_q == '0) begin
                     state_d = ST_FAULT;
                  end else begin
                     pc_d    = stack_q[top_idx];
                     depth_d = depth_q - DW'(1);
                  end
               end else if (bus.Call) begin
                  if (depth_q == DW'(DEPTH)) begin
                     state_d = ST_FAULT;
                  end else begin
                     push_en = 1'b1;
                     depth_d = depth_q + DW'(1);
                     pc_d    = bus.Jump_Addr;
                  end
               end else if (bus.Jump) begin
                  pc_d = bus.Jump_Addr;
               end else if (bus.Branch_Taken) begin
                  pc_d = branch_target(pc_q, bus.Branch_Offset);
               end else begin
                  pc_d = bus.Next_PC;
               end
            end
         end
         ST_HALT: begin
            if (bus.Resume) begin
               state_d = ST_RUN;
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_FAULT;
         end
      endcase
   end

   // Control registers: PC, stack depth and state, async cleared.
   always_ff @(posedge Clk or negedge Clear_n) begin
      if (!Clear_n) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
         depth_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         depth_q <= depth_d;
      end
   end

   // Return-address storage; contents are don't-care after reset.
   always_ff @(posedge Clk) begin
      if (push_en) begin
         stack_q[push_idx] <= bus.Next_PC;
      end
   end

   assign bus.PC          = pc_q;
   assign bus.Stack_Depth = depth_q;
   assign bus.Halted      = (state_q == ST_HALT);
   assign bus.Fault       = (state_q == ST_FAULT);
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each step drives controls, pushes the
// expected PC/depth/status into a scoreboard queue, and pops/compares after
// the following rising edge.
module tb_pc_sequencer;
   localparam int AW    = 8;
   localparam int DEPTH = 4;
   localparam int DW    = $clog2(DEPTH) + 1;

   typedef struct {
      string         tag;
      logic [AW-1:0] pc;
      logic [DW-1:0] depth;
      logic          halted;
      logic          fault;
   } exp_t;

   logic Clk;
   logic Clear_n;
   int   n_cmp;
   int   n_err;
   exp_t sb[$];
   logic [AW-1:0] cur_pc;

   pc_sequencer_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

   pc_sequencer #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
      .Clk     (Clk),
      .Clear_n (Clear_n),
      .bus     (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chk_all(input exp_t e);
      chk({e.tag, ".pc"},     32'(bus.PC),          32'(e.pc));
      chk({e.tag, ".depth"},  32'(bus.Stack_Depth), 32'(e.depth));
      chk({e.tag, ".halted"}, 32'(bus.Halted),      32'(e.halted));
      chk({e.tag, ".fault"},  32'(bus.Fault),       32'(e.fault));
   endtask

   // All controls idle; successor follows the expected PC.
   task automatic idle();
      bus.Next_PC       = cur_pc + 8'h01;
      bus.Stall         = 1'b0;
      bus.Branch_Taken  = 1'b0;
      bus.Branch_Offset = 8'h00;
      bus.Jump          = 1'b0;
      bus.Jump_Addr     = 8'h00;
      bus.Call          = 1'b0;
      bus.Ret           = 1'b0;
      bus.Halt          = 1'b0;
      bus.Resume        = 1'b0;
   endtask

   task automatic tick(input string tag, input logic [AW-1:0] pc, input logic [DW-1:0] depth,
                       input logic h, input logic f);
      exp_t e;
      e.tag = tag; e.pc = pc; e.depth = depth; e.halted = h; e.fault = f;
      sb.push_back(e);
      @(posedge Clk);
      #1;
      if (sb.size() == 0) begin
         n_cmp++; n_err++;
         $display("FAIL %s: observed empty scoreboard expected entry", tag);
      end else begin
         e = sb.pop_front();
         chk_all(e);
      end
      cur_pc = pc;
      idle();
   endtask

   task automatic async_reset(input string tag);
      exp_t e;
      #2;
      Clear_n = 1'b0;
      #1;
      e.tag = tag; e.pc = 8'h00; e.depth = '0; e.halted = 1'b0; e.fault = 1'b0;
      chk_all(e);
      cur_pc = 8'h00;
      idle();
      @(negedge Clk);
      Clear_n = 1'b1;
   endtask

   initial begin
      n_cmp  = 0;
      n_err  = 0;
      cur_pc = 8'h00;
      idle();
      Clear_n = 1'b0;
      #3;
      begin
         exp_t e;
         e.tag = "por"; e.pc = 8'h00; e.depth = '0; e.halted = 1'b0; e.fault = 1'b0;
         chk_all(e);
      end
      Clear_n = 1'b1;
      @(negedge Clk);

      // 1. Reset mid-call with PC=0x37, then sequential run
      bus.Call = 1'b1; bus.Jump_Addr = 8'h37;
      tick("call37", 8'h37, 3'd1, 1'b0, 1'b0);
      async_reset("rst_mid");
      tick("seq1", 8'h01, 3'd0, 1'b0, 1'b0);
      tick("seq2", 8'h02, 3'd0, 1'b0, 1'b0);
      tick("seq3", 8'h03, 3'd0, 1'b0, 1'b0);

      // 2. Branch wrap in both directions, stall
      bus.Jump = 1'b1; bus.Jump_Addr = 8'h02;
      tick("jmp02", 8'h02, 3'd0, 1'b0, 1'b0);
      bus.Branch_Taken = 1'b1; bus.Branch_Offset = 8'hFC;
      tick("br_neg", 8'hFE, 3'd0, 1'b0, 1'b0);
      bus.Branch_Taken = 1'b1; bus.Branch_Offset = 8'h05;
      tick("br_pos", 8'h03, 3'd0, 1'b0, 1'b0);
      bus.Stall = 1'b1; bus.Branch_Taken = 1'b1; bus.Branch_Offset = 8'h10;
      tick("stall_br", 8'h03, 3'd0, 1'b0, 1'b0);
      bus.Stall = 1'b1; bus.Call = 1'b1; bus.Halt = 1'b1; bus.Jump_Addr = 8'h99;
      tick("stall_call", 8'h03, 3'd0, 1'b0, 1'b0);

      // 3. Nested call / return
      bus.Jump = 1'b1; bus.Jump_Addr = 8'h10;
      tick("jmp10", 8'h10, 3'd0, 1'b0, 1'b0);
      bus.Call = 1'b1; bus.Jump_Addr = 8'h80;
      tick("call80", 8'h80, 3'd1, 1'b0, 1'b0);
      bus.Call = 1'b1; bus.Jump_Addr = 8'hA0;
      tick("callA0", 8'hA0, 3'd2, 1'b0, 1'b0);
      bus.Ret = 1'b1;
      tick("ret81", 8'h81, 3'd1, 1'b0, 1'b0);
      bus.Ret = 1'b1;
      tick("ret11", 8'h11, 3'd0, 1'b0, 1'b0);
      tick("seq12", 8'h12, 3'd0, 1'b0, 1'b0);

      // 5. Priority
      bus.Halt = 1'b1; bus.Ret = 1'b1; bus.Call = 1'b1; bus.Jump = 1'b1; bus.Jump_Addr = 8'h55;
      tick("prio_halt", 8'h12, 3'd0, 1'b1, 1'b0);
      bus.Resume = 1'b1;
      tick("resume", 8'h12, 3'd0, 1'b0, 1'b0);
      bus.Call = 1'b1; bus.Jump = 1'b1; bus.Branch_Taken = 1'b1;
      bus.Branch_Offset = 8'h10; bus.Jump_Addr = 8'h40;
      tick("prio_call", 8'h40, 3'd1, 1'b0, 1'b0);

      // 6. HALT ignores everything but Resume, including Stall
      bus.Halt = 1'b1;
      tick("halt", 8'h40, 3'd1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         bus.Call = 1'b1; bus.Jump = 1'b1; bus.Jump_Addr = 8'h77; bus.Stall = 1'b1;
         bus.Ret = 1'b1; bus.Branch_Taken = 1'b1; bus.Branch_Offset = 8'h08;
         tick("halt_hold", 8'h40, 3'd1, 1'b1, 1'b0);
      end
      bus.Resume = 1'b1; bus.Stall = 1'b1;
      tick("resume_stall", 8'h40, 3'd1, 1'b0, 1'b0);
      tick("seq41", 8'h41, 3'd1, 1'b0, 1'b0);
      bus.Ret = 1'b1;
      tick("ret13", 8'h13, 3'd0, 1'b0, 1'b0);

      // 4. Underflow, then overflow
      bus.Ret = 1'b1;
      tick("underflow", 8'h13, 3'd0, 1'b0, 1'b1);
      bus.Jump = 1'b1; bus.Jump_Addr = 8'h66;
      tick("fault_jmp", 8'h13, 3'd0, 1'b0, 1'b1);
      bus.Resume = 1'b1;
      tick("fault_res", 8'h13, 3'd0, 1'b0, 1'b1);
      async_reset("rst_fault");
      bus.Call = 1'b1; bus.Jump_Addr = 8'h20;
      tick("ovf_c1", 8'h20, 3'd1, 1'b0, 1'b0);
      bus.Call = 1'b1; bus.Jump_Addr = 8'h30;
      tick("ovf_c2", 8'h30, 3'd2, 1'b0, 1'b0);
      bus.Call = 1'b1; bus.Jump_Addr = 8'h40;
      tick("ovf_c3", 8'h40, 3'd3, 1'b0, 1'b0);
      bus.Call = 1'b1; bus.Jump_Addr = 8'h50;
      tick("ovf_c4", 8'h50, 3'd4, 1'b0, 1'b0);
      bus.Call = 1'b1; bus.Jump_Addr = 8'h60;
      tick("ovf_c5", 8'h50, 3'd4, 1'b0, 1'b1);
      bus.Ret = 1'b1;
      tick("ovf_ret", 8'h50, 3'd4, 1'b0, 1'b1);
      bus.Jump = 1'b1; bus.Jump_Addr = 8'h70;
      tick("ovf_jmp", 8'h50, 3'd4, 1'b0, 1'b1);
      async_reset("rst_ovf");

      // Successor wrap 0xFF -> 0x00 accepted as supplied
      bus.Jump = 1'b1; bus.Jump_Addr = 8'hFF;
      tick("jmpFF", 8'hFF, 3'd0, 1'b0, 1'b0);
      tick("wrap00", 8'h00, 3'd0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
